// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ writeback sources.
// Optional forwarding taps are enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wb_stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
`ifdef RF_WB_BYPASS_EN
   input  logic [ADDR_W-1:0]         byp_addr1,
   input  logic [ADDR_W-1:0]         byp_addr2,
   output logic                      byp_hit1,
   output logic                      byp_hit2,
   output logic [DATA_W-1:0]         byp_data1,
   output logic [DATA_W-1:0]         byp_data2,
`endif
   output logic                      rf_write_enable,
   output logic [ADDR_W-1:0]         rf_write_addr,
   output logic [DATA_W-1:0]         rf_write_data
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned IDX_W = PTR_W + 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [NUM_REQ-1:0] gnt;
   logic               found;
   logic [IDX_W-1:0]   slot;
   logic               xfer;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;

   // Rotating priority scan starting at ptr; slot wraps modulo NUM_REQ
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      slot  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = IDX_W'(ptr_q) + IDX_W'(k);
         if (slot >= IDX_W'(NUM_REQ)) slot = slot - IDX_W'(NUM_REQ);
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && (slot == IDX_W'(j)) && req_valid[j]) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
      if (wb_stall || !rst_n) gnt = '0;
   end

   assign req_ready = gnt;
   assign xfer      = |gnt;

   // Grant-selected payload and next-state for pointer and write port
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      ptr_d    = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
            sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            ptr_d    = PTR_W'((i + 1) % NUM_REQ);
         end
      end
      we_d   = xfer && (sel_addr != '0);
      addr_d = xfer ? sel_addr : addr_q;
      data_d = xfer ? sel_data : data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign rf_write_enable = we_q;
   assign rf_write_addr   = addr_q;
   assign rf_write_data   = data_q;

`ifdef RF_WB_BYPASS_EN
   // Forward the value being written this cycle to same-cycle readers
   assign byp_hit1  = we_q && (addr_q == byp_addr1) && (byp_addr1 != '0);
   assign byp_hit2  = we_q && (addr_q == byp_addr2) && (byp_addr2 != '0);
   assign byp_data1 = data_q;
   assign byp_data2 = data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (3 requesters, 5-bit addr, 32-bit data).
module tb_rf_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wb_stall;
   logic [N-1:0]     req_valid;
   logic [N*AW-1:0]  req_addr;
   logic [N*DW-1:0]  req_data;
   logic [N-1:0]     req_ready;
   logic             rf_write_enable;
   logic [AW-1:0]    rf_write_addr;
   logic [DW-1:0]    rf_write_data;
`ifdef RF_WB_BYPASS_EN
   logic [AW-1:0]    byp_addr1, byp_addr2;
   logic             byp_hit1, byp_hit2;
   logic [DW-1:0]    byp_data1, byp_data2;
`endif

   int errors = 0;
   int checks = 0;

   rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .wb_stall        (wb_stall),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .req_data        (req_data),
      .req_ready       (req_ready),
`ifdef RF_WB_BYPASS_EN
      .byp_addr1       (byp_addr1),
      .byp_addr2       (byp_addr2),
      .byp_hit1        (byp_hit1),
      .byp_hit2        (byp_hit2),
      .byp_data1       (byp_data1),
      .byp_data2       (byp_data2),
`endif
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      chk({tag, "_we"},   64'(rf_write_enable), 64'(we));
      chk({tag, "_addr"}, 64'(rf_write_addr),   64'(a));
      chk({tag, "_data"}, 64'(rf_write_data),   64'(d));
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      rst_n     = 1'b0;
      wb_stall  = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
`ifdef RF_WB_BYPASS_EN
      byp_addr1 = '0;
      byp_addr2 = '0;
`endif
      // Reset: ready forced low even with a valid request
      tick();
      req_valid = 3'b001;
      #1;
      chk("rst_ready", 64'(req_ready), 64'(3'b000));
      chk_wr("rst", 1'b0, '0, '0);
      tick();
      req_valid = '0;
      rst_n     = 1'b1;
      tick();
      chk_wr("post_rst", 1'b0, '0, '0);
      chk("post_rst_ready", 64'(req_ready), 64'(3'b000));

      // Single request from req0 (ptr 0 -> 1)
      set_req(0, 5'd5, 32'h1234_5678);
      req_valid = 3'b001;
      #1;
      chk("single_ready", 64'(req_ready), 64'(3'b001));
      tick();
      req_valid = '0;
      chk_wr("single_wr", 1'b1, 5'd5, 32'h1234_5678);
      #1;
      chk("single_idle_ready", 64'(req_ready), 64'(3'b000));
      tick();
      chk_wr("single_after", 1'b0, 5'd5, 32'h1234_5678);

      // Write to x0 from req1 is consumed with no write (ptr 1 -> 2)
      set_req(1, 5'd0, 32'hFFFF_FFFF);
      req_valid = 3'b010;
      #1;
      chk("x0_ready", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0;
      chk_wr("x0_wr", 1'b0, 5'd0, 32'hFFFF_FFFF);

      // Stall two cycles with req2 waiting (ptr 2 -> 0)
      set_req(2, 5'd7, 32'h0000_0777);
      req_valid = 3'b100;
      wb_stall  = 1'b1;
      #1;
      chk("stall_ready0", 64'(req_ready), 64'(3'b000));
      tick();
      chk("stall_ready1", 64'(req_ready), 64'(3'b000));
      chk("stall_we1", 64'(rf_write_enable), 64'(1'b0));
      tick();
      chk("stall_we2", 64'(rf_write_enable), 64'(1'b0));
      wb_stall = 1'b0;
      #1;
      chk("unstall_ready", 64'(req_ready), 64'(3'b100));
      tick();
      req_valid = '0;
      chk_wr("unstall_wr", 1'b1, 5'd7, 32'h0000_0777);

      // All three valid: grants rotate with one write per cycle (ptr ends at 1)
      set_req(0, 5'd1, 32'hA1);
      set_req(1, 5'd2, 32'hA2);
      set_req(2, 5'd3, 32'hA3);
      req_valid = 3'b111;
      #1;
      chk("rr_ready0", 64'(req_ready), 64'(3'b001));
      tick();
      chk_wr("rr_wr0", 1'b1, 5'd1, 32'hA1);
      chk("rr_ready1", 64'(req_ready), 64'(3'b010));
      tick();
      chk_wr("rr_wr1", 1'b1, 5'd2, 32'hA2);
      chk("rr_ready2", 64'(req_ready), 64'(3'b100));
      tick();
      chk_wr("rr_wr2", 1'b1, 5'd3, 32'hA3);
      chk("rr_ready3", 64'(req_ready), 64'(3'b001));
      tick();
      chk_wr("rr_wr3", 1'b1, 5'd1, 32'hA1);
      chk("rr_ready4", 64'(req_ready), 64'(3'b010));
      req_valid = '0;
      #1;
      chk("rr_drop_ready", 64'(req_ready), 64'(3'b000));
      tick();
      chk_wr("rr_idle", 1'b0, 5'd1, 32'hA1);

`ifdef RF_WB_BYPASS_EN
      // Forwarding taps while x9 is being written (ptr 1 -> 2)
      set_req(1, 5'd9, 32'hCAFE_0001);
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      byp_addr1 = 5'd9;
      byp_addr2 = 5'd0;
      #1;
      chk("byp_hit1", 64'(byp_hit1), 64'(1'b1));
      chk("byp_data1", 64'(byp_data1), 64'(32'hCAFE_0001));
      chk("byp_hit2", 64'(byp_hit2), 64'(1'b0));
      byp_addr2 = 5'd9;
      #1;
      chk("byp_hit2_same", 64'(byp_hit2), 64'(1'b1));
      tick();
      chk("byp_hit1_idle", 64'(byp_hit1), 64'(1'b0));
`endif

      // Reset mid-write discards pending write and returns ptr to 0
      set_req(0, 5'd4, 32'h44);
      req_valid = 3'b001;
      #1;
      chk("mid_ready", 64'(req_ready), 64'(3'b001));
      tick();
      req_valid = '0;
      chk("mid_we", 64'(rf_write_enable), 64'(1'b1));
      rst_n = 1'b0;
      #1;
      chk_wr("mid_rst", 1'b0, '0, '0);
      tick();
      rst_n = 1'b1;
      set_req(0, 5'd6, 32'h66);
      set_req(1, 5'd8, 32'h88);
      req_valid = 3'b011;
      #1;
      chk("mid_ptr0_ready", 64'(req_ready), 64'(3'b001));
      tick();
      chk_wr("mid_post_wr", 1'b1, 5'd6, 32'h66);
      chk("mid_next_ready", 64'(req_ready), 64'(3'b010));
      req_valid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
